// File: rtl/even_parity_frame_rx.sv
// even_parity_frame_rx: serial receiver for start/data/even-parity/stop frames with a valid/ready word output
module even_parity_frame_rx #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              serial_in,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);
    localparam int CNT_W = DATA_W > 1 ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} stateT;
    stateT state, nextState;
    logic [CNT_W-1:0] bitCnt;
    logic [DATA_W-1:0] shiftReg;
    logic parityBit;
    logic complete, load, drop;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= nextState;
    end
    always_comb begin
        nextState = !bit_en ? state :
                    state == IDLE ? (serial_in ? IDLE : DATA) :
                    state == DATA ? (bitCnt == LAST_IDX ? PARITY : DATA) :
                    state == PARITY ? STOP : IDLE;
        complete = bit_en && state == STOP;
        load = complete && (!out_valid || out_ready);
        drop = complete && out_valid && !out_ready;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitCnt <= '0;
            shiftReg <= '0;
            parityBit <= 1'b0;
            out_valid <= 1'b0;
            data_out <= '0;
            parity_err <= 1'b0;
            frame_err <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (bit_en && state == IDLE) bitCnt <= '0;
            if (bit_en && state == DATA) begin
                shiftReg[bitCnt] <= serial_in;
                bitCnt <= bitCnt + 1'b1;
            end
            if (bit_en && state == PARITY) parityBit <= serial_in;
            if (load) begin
                data_out <= shiftReg;
                parity_err <= ^{shiftReg, parityBit};
                frame_err <= !serial_in;
            end
            out_valid <= load || (out_valid && !out_ready);
            if (drop) overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_even_parity_frame_rx.sv
// tb_even_parity_frame_rx: directed frames with a queue scoreboard checked by an independent output monitor
module tb_even_parity_frame_rx;
    logic clk = 1'b0;
    logic rst_n, bit_en, serial_in, out_ready;
    logic out_valid, parity_err, frame_err, overrun;
    logic [3:0] data_out;
    logic [5:0] sb[$];
    logic [5:0] expWord;
    logic seen = 1'b0;
    int vectors = 0;
    int errors = 0;

    even_parity_frame_rx #(.DATA_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .serial_in(serial_in), .out_ready(out_ready),
        .out_valid(out_valid), .data_out(data_out), .parity_err(parity_err),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sendBit(input logic b);
        serial_in = b;
        bit_en = 1'b1;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
        serial_in = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic sendBody(input logic [3:0] d, input logic p);
        sendBit(1'b0);
        for (int i = 0; i < 4; i++) sendBit(d[i]);
        sendBit(p);
    endtask

    task automatic sendFrame(input logic [3:0] d, input logic p, input logic s);
        sendBody(d, p);
        sendBit(s);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_data"}, 32'(data_out), 32'd0);
        check({tag, "_perr"}, 32'(parity_err), 32'd0);
        check({tag, "_ferr"}, 32'(frame_err), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) seen = 1'b0;
        else begin
            if (out_valid && !seen) begin
                if (sb.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected no word", data_out);
                end else begin
                    expWord = sb.pop_front();
                    check("word_data", 32'(data_out), 32'(expWord[5:2]));
                    check("word_perr", 32'(parity_err), 32'(expWord[1]));
                    check("word_ferr", 32'(frame_err), 32'(expWord[0]));
                end
                seen = 1'b1;
            end
            if (out_valid && out_ready) seen = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        bit_en = 1'b0;
        serial_in = 1'b1;
        out_ready = 1'b1;
        #2;
        checkAllZero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back({4'b1011, 1'b0, 1'b0});
        sendFrame(4'b1011, 1'b1, 1'b1);
        check("one_cycle_valid", 32'(out_valid), 32'd0);
        sb.push_back({4'b1011, 1'b1, 1'b0});
        sendFrame(4'b1011, 1'b0, 1'b1);
        sb.push_back({4'b0000, 1'b0, 1'b0});
        sendFrame(4'b0000, 1'b0, 1'b1);
        sb.push_back({4'b0001, 1'b0, 1'b1});
        sendFrame(4'b0001, 1'b1, 1'b0);
        sb.push_back({4'h6, 1'b1, 1'b1});
        sendFrame(4'h6, 1'b1, 1'b0);
        sb.push_back({4'h9, 1'b0, 1'b0});
        sendFrame(4'h9, 1'b0, 1'b1);
        out_ready = 1'b0;
        sb.push_back({4'h3, 1'b0, 1'b0});
        sendFrame(4'h3, 1'b0, 1'b1);
        sendFrame(4'h5, 1'b0, 1'b1);
        check("held_data", 32'(data_out), 32'h3);
        check("held_valid", 32'(out_valid), 32'd1);
        check("overrun_set", 32'(overrun), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("accept_valid", 32'(out_valid), 32'd0);
        check("overrun_sticky", 32'(overrun), 32'd1);
        rst_n = 1'b0;
        #2;
        check("rst2_overrun", 32'(overrun), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b0;
        sb.push_back({4'h3, 1'b0, 1'b0});
        sendFrame(4'h3, 1'b0, 1'b1);
        sb.push_back({4'h5, 1'b0, 1'b0});
        sendBody(4'h5, 1'b0);
        out_ready = 1'b1;
        serial_in = 1'b1;
        bit_en = 1'b1;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
        check("same_edge_valid", 32'(out_valid), 32'd1);
        check("same_edge_data", 32'(data_out), 32'h5);
        check("same_edge_overrun", 32'(overrun), 32'd0);
        @(posedge clk);
        #1;
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        rst_n = 1'b0;
        #2;
        checkAllZero("midframe_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.push_back({4'hA, 1'b0, 1'b0});
        sendFrame(4'hA, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", 32'(sb.size()), 32'd0);
        check("final_overrun", 32'(overrun), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
